// File: rtl/icache_ctrl_pkg.sv
// Shared types and state encodings for the direct-mapped instruction cache.
package icache_ctrl_pkg;

  localparam int unsigned DATA_BITS = 32;

  // Reused 32-bit bus type (DATA_TYPE in the legacy definitions).
  typedef logic [DATA_BITS-1:0] data_t;

  // Default geometry; modules derive their own widths from their parameters.
  localparam int unsigned ICACHE_INDEX_BITS = 8;
  localparam int unsigned ICACHE_ADDR_BITS  = 18;
  localparam int unsigned ICACHE_TAG_BITS   = ICACHE_ADDR_BITS - ICACHE_INDEX_BITS - 2;

  typedef logic [ICACHE_INDEX_BITS-1:0] icache_index_t;
  typedef logic [ICACHE_TAG_BITS-1:0]   icache_tag_t;

  typedef logic [1:0] ic_state_t;
  localparam ic_state_t IC_IDLE = 2'd0;
  localparam ic_state_t IC_MISS = 2'd1;
  localparam ic_state_t IC_RESP = 2'd2;

  function automatic data_t word_align(input data_t addr);
    return {addr[DATA_BITS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one write port,
// synchronous clear of every valid bit on reset.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output data_t                 rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  data_t                 wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  data_t               data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only trusted behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: hit path, single-word refill
// and mispredict flush between the fetcher and the memory controller.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned ADDR_BITS  = 18
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  input  logic  in_fetcher_flag,
  input  data_t in_fetcher_addr,
  output logic  out_fetcher_flag,
  output data_t out_fetcher_inst,
  output logic  out_mem_flag,
  output data_t out_mem_addr,
  input  logic  in_mem_flag,
  input  data_t in_mem_data,
  input  logic  in_rob_xbp
);

  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  ic_state_t             state_q, state_d;
  logic [INDEX_BITS-1:0] miss_index_q, miss_index_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic                  fetch_flag_q, fetch_flag_d;
  data_t                 fetch_inst_q, fetch_inst_d;
  logic                  mem_flag_q, mem_flag_d;
  data_t                 mem_addr_q, mem_addr_d;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  data_t                 rd_data;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_addr_lsb;

  assign req_index       = in_fetcher_addr[INDEX_BITS+1:2];
  assign req_tag         = in_fetcher_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign unused_addr_lsb = ^in_fetcher_addr[1:0];

  assign hit = rd_valid && (rd_tag == req_tag);

  // The refill is written even when a flush lands in the same cycle: the data is correct.
  assign fill_en = rdy && (state_q == IC_MISS) && in_mem_flag;

  icache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_index(req_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_en),
    .wr_index(miss_index_q),
    .wr_tag  (miss_tag_q),
    .wr_data (in_mem_data)
  );

  always_comb begin
    state_d      = state_q;
    miss_index_d = miss_index_q;
    miss_tag_d   = miss_tag_q;
    fetch_flag_d = fetch_flag_q;
    fetch_inst_d = fetch_inst_q;
    mem_flag_d   = mem_flag_q;
    mem_addr_d   = mem_addr_q;

    if (rdy) begin
      if (in_rob_xbp) begin
        state_d      = IC_IDLE;
        fetch_flag_d = 1'b0;
        mem_flag_d   = 1'b0;
      end else begin
        case (state_q)
          IC_IDLE: begin
            fetch_flag_d = 1'b0;
            if (in_fetcher_flag) begin
              if (hit) begin
                fetch_inst_d = rd_data;
                fetch_flag_d = 1'b1;
                state_d      = IC_RESP;
              end else begin
                miss_index_d = req_index;
                miss_tag_d   = req_tag;
                mem_addr_d   = word_align(in_fetcher_addr);
                mem_flag_d   = 1'b1;
                state_d      = IC_MISS;
              end
            end
          end
          IC_MISS: begin
            if (in_mem_flag) begin
              mem_flag_d   = 1'b0;
              fetch_inst_d = in_mem_data;
              fetch_flag_d = 1'b1;
              state_d      = IC_RESP;
            end
          end
          IC_RESP: begin
            // The fetcher may still hold its old request here, so nothing is sampled.
            fetch_flag_d = 1'b0;
            state_d      = IC_IDLE;
          end
          default: begin
            fetch_flag_d = 1'b0;
            mem_flag_d   = 1'b0;
            state_d      = IC_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IC_IDLE;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
      fetch_flag_q <= 1'b0;
      fetch_inst_q <= '0;
      mem_flag_q   <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_index_q <= miss_index_d;
      miss_tag_q   <= miss_tag_d;
      fetch_flag_q <= fetch_flag_d;
      fetch_inst_q <= fetch_inst_d;
      mem_flag_q   <= mem_flag_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign out_fetcher_flag = fetch_flag_q;
  assign out_fetcher_inst = fetch_inst_q;
  assign out_mem_flag     = mem_flag_q;
  assign out_mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl against a line-array reference model.
module tb_icache_ctrl;

  localparam int MODE_FILL       = 0;
  localparam int MODE_FLUSH_WAIT = 1;
  localparam int MODE_FILL_FLUSH = 2;
  localparam int MODE_FLUSH_REQ  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_fetcher_flag;
  logic [31:0] in_fetcher_addr;
  logic        out_fetcher_flag;
  logic [31:0] out_fetcher_inst;
  logic        out_mem_flag;
  logic [31:0] out_mem_addr;
  logic        in_mem_flag;
  logic [31:0] in_mem_data;
  logic        in_rob_xbp;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: one entry per line (256 lines, tag = addr[17:10]).
  bit          m_valid [256];
  logic [7:0]  m_tag   [256];
  logic [31:0] m_data  [256];

  always #5 clk = ~clk;

  icache_ctrl #(
    .INDEX_BITS(8),
    .ADDR_BITS (18)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_fetcher_flag (in_fetcher_flag),
    .in_fetcher_addr (in_fetcher_addr),
    .out_fetcher_flag(out_fetcher_flag),
    .out_fetcher_inst(out_fetcher_inst),
    .out_mem_flag    (out_mem_flag),
    .out_mem_addr    (out_mem_addr),
    .in_mem_flag     (in_mem_flag),
    .in_mem_data     (in_mem_data),
    .in_rob_xbp      (in_rob_xbp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch transaction; checks cycle-exact behaviour against the model.
  task automatic fetch(input logic [31:0] addr, input int mode, input int lat,
                       input logic [31:0] fill, input bit stall);
    int unsigned idx;
    logic [7:0]  tg;
    logic [31:0] aligned;
    logic [31:0] exp_inst;
    bit          hit;
    idx      = int'(addr[9:2]);
    tg       = addr[17:10];
    aligned  = addr & 32'hFFFF_FFFC;
    hit      = m_valid[idx] && (m_tag[idx] == tg);
    exp_inst = m_data[idx];

    in_fetcher_flag = 1'b1;
    in_fetcher_addr = addr;
    in_rob_xbp      = (mode == MODE_FLUSH_REQ);
    step();
    in_rob_xbp = 1'b0;

    if (mode == MODE_FLUSH_REQ) begin
      in_fetcher_flag = 1'b0;
      check("flushreq_flag", 32'(out_fetcher_flag), 32'd0);
      check("flushreq_mem", 32'(out_mem_flag), 32'd0);
      step();
      check("flushreq_after", 32'(out_fetcher_flag | out_mem_flag), 32'd0);
      return;
    end

    if (hit) begin
      in_fetcher_flag = 1'b0;
      check("hit_flag", 32'(out_fetcher_flag), 32'd1);
      check("hit_inst", out_fetcher_inst, exp_inst);
      check("hit_mem", 32'(out_mem_flag), 32'd0);
    end else begin
      check("miss_req", 32'(out_mem_flag), 32'd1);
      check("miss_addr", out_mem_addr, aligned);
      check("miss_noflag", 32'(out_fetcher_flag), 32'd0);
      for (int i = 0; i < lat; i++) begin
        step();
        check("miss_hold", 32'(out_mem_flag), 32'd1);
        check("miss_addr_hold", out_mem_addr, aligned);
        check("miss_wait_noflag", 32'(out_fetcher_flag), 32'd0);
      end
      if (mode == MODE_FLUSH_WAIT) begin
        in_rob_xbp      = 1'b1;
        in_fetcher_flag = 1'b0;
        step();
        in_rob_xbp = 1'b0;
        check("fw_mem", 32'(out_mem_flag), 32'd0);
        check("fw_flag", 32'(out_fetcher_flag), 32'd0);
        in_mem_flag = 1'b1;
        in_mem_data = fill;
        step();
        in_mem_flag = 1'b0;
        check("late_flag", 32'(out_fetcher_flag), 32'd0);
        check("late_mem", 32'(out_mem_flag), 32'd0);
        return;
      end
      in_mem_flag = 1'b1;
      in_mem_data = fill;
      in_rob_xbp  = (mode == MODE_FILL_FLUSH);
      step();
      in_mem_flag     = 1'b0;
      in_rob_xbp      = 1'b0;
      in_fetcher_flag = 1'b0;
      m_valid[idx]    = 1'b1;
      m_tag[idx]      = tg;
      m_data[idx]     = fill;
      exp_inst        = fill;
      if (mode == MODE_FILL_FLUSH) begin
        check("ff_flag", 32'(out_fetcher_flag), 32'd0);
        check("ff_mem", 32'(out_mem_flag), 32'd0);
        return;
      end
      check("fill_flag", 32'(out_fetcher_flag), 32'd1);
      check("fill_inst", out_fetcher_inst, exp_inst);
      check("fill_mem", 32'(out_mem_flag), 32'd0);
    end

    if (stall) begin
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        check("stall_flag", 32'(out_fetcher_flag), 32'd1);
        check("stall_inst", out_fetcher_inst, exp_inst);
        check("stall_mem", 32'(out_mem_flag), 32'd0);
      end
      rdy = 1'b1;
    end
    step();
    check("resp_end", 32'(out_fetcher_flag), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    int          mode;
    rst             = 1'b1;
    rdy             = 1'b1;
    in_fetcher_flag = 1'b0;
    in_fetcher_addr = '0;
    in_mem_flag     = 1'b0;
    in_mem_data     = '0;
    in_rob_xbp      = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    repeat (3) step();
    check("rst_fetch_flag", 32'(out_fetcher_flag), 32'd0);
    check("rst_fetch_inst", out_fetcher_inst, 32'd0);
    check("rst_mem_flag", 32'(out_mem_flag), 32'd0);
    check("rst_mem_addr", out_mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // Directed scenarios.
    fetch(32'h0000_0000, MODE_FILL, 3, 32'h0000_0513, 1'b0);
    fetch(32'h0000_0000, MODE_FILL, 0, 32'h0, 1'b0);
    fetch(32'h0000_0400, MODE_FILL, 1, 32'h0010_0093, 1'b0);
    fetch(32'h0000_0000, MODE_FILL, 2, 32'h0000_0513, 1'b0);
    fetch(32'h0000_0010, MODE_FLUSH_WAIT, 2, 32'h1111_1111, 1'b0);
    fetch(32'h0000_0010, MODE_FILL, 0, 32'h2222_2222, 1'b0);
    fetch(32'h0000_0008, MODE_FILL_FLUSH, 1, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h0000_0008, MODE_FILL, 0, 32'h0, 1'b1);
    fetch(32'h0000_0010, MODE_FLUSH_REQ, 0, 32'h0, 1'b0);

    // Random traffic over a small set of lines and tags to force hits and conflicts.
    repeat (400) begin
      addr = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 3)) << 10)
           | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0)      mode = MODE_FLUSH_REQ;
      else if (r == 1) mode = MODE_FLUSH_WAIT;
      else if (r == 2) mode = MODE_FILL_FLUSH;
      else             mode = MODE_FILL;
      fetch(addr, mode, $urandom_range(0, 4), $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
